frame_buf_reader: RTL and testbench
===================================

FRAME_BUF_READER -- requirements
Module: frame_buf_reader

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 The block SHALL have the following parameters:
- IMG_W, 320, source image width in pixels.
- IMG_H, 240, source image height in pixels.
- DISP_W, 640, active display width.
- DISP_H, 480, active display height.
- RAM_LAT, 1, frame-RAM read latency in cycles (legal 1..3).
- AW, $clog2(IMG_W*IMG_H), address width.
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  pixel clock.
- rst_n  in  1  async active-low reset.
- DE  in  1  display-enable from the timing generator.
- x_pixel  in  10  current column.
- y_pixel  in  10  current row.
- h_sync  in  1  horizontal sync, active-high.
- v_sync  in  1  vertical sync, active-high.
- mode  in  2  display mode request.
- border_rgb  in  12  {r,g,b} border colour.
- addr  out  AW  frame-RAM read address.
- rd_en  out  1  frame-RAM read strobe.
- imgData  in  16  RGB565 word from RAM, RAM_LAT cycles after addr/rd_en.
- r_port  out  4  red.
- g_port  out  4  green.
- b_port  out  4  blue.
- de_o  out  1  delayed DE.
- h_sync_o  out  1  delayed h_sync.
- v_sync_o  out  1  delayed v_sync.

Function
REQ-004 The block SHALL treat a pixel as active when DE=1, x_pixel<DISP_W and y_pixel<DISP_H.
REQ-005 The block SHALL register addr and rd_en on the clk edge that samples the pixel inputs (1-cycle latency).
REQ-006 For an inactive pixel, or in modes 10-outside-window and 11, the block SHALL drive rd_en=0 and addr=0.
REQ-007 Mode 00 (2x upscale) SHALL use addr = (y>>1)*IMG_W + (x>>1).
REQ-008 Mode 01 (tile) SHALL use addr = (y mod IMG_H)*IMG_W + (x mod IMG_W).
REQ-009 Mode 10 (1x centred) SHALL define the window OX=(DISP_W-IMG_W)/2, OY=(DISP_H-IMG_H)/2.
- Inside the window: addr=(y-OY)*IMG_W+(x-OX).
- Outside the window: the pixel colour SHALL be border_rgb.
REQ-010 Mode 11 (colour bars) SHALL divide DISP_W into 8 equal bars, left to right:
- FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
REQ-011 All address arithmetic SHALL be unsigned, SHALL use no multiplier primitive for constant IMG_W (shift-add is acceptable), and SHALL be truncated to AW bits.
REQ-012 Each pixel SHALL carry a 2-bit source tag (IMAGE, BORDER, BAR, BLANK) plus the bar index through a delay line of RAM_LAT stages, aligned with the RAM data.
REQ-013 Outputs r_port/g_port/b_port, de_o, h_sync_o and v_sync_o for a pixel presented in cycle n SHALL be registered and valid in cycle n+RAM_LAT+1.
REQ-014 Colour selection by source tag SHALL be:
- IMAGE -> {imgData[15:12], imgData[10:7], imgData[4:1]}.
- BORDER -> border_rgb.
- BAR -> bar colour.
- BLANK -> 000.
REQ-015 Colour outputs SHALL be 000 whenever de_o=0.
REQ-016 mode SHALL be latched into mode_q only in the cycle after a v_sync rising edge (0->1 across consecutive samples).
- All address and tag decisions SHALL use mode_q, never the live mode input.
- A mode change mid-frame SHALL therefore take effect at the next frame.
REQ-017 If a v_sync rising edge and a mode change occur in the same cycle, the block SHALL latch the new mode value.
REQ-018 A pixel at x=DISP_W-1 followed by x=0 SHALL need no special handling, because the pipeline is per-pixel and stateless apart from the delay line and mode_q.

Reset
REQ-019 While rst_n=0, the block SHALL immediately hold:
- addr=0, rd_en=0.
- r/g/b=0, de_o=0, h_sync_o=0, v_sync_o=0.
- All delay-line stages BLANK/0.
- mode_q=00.
- The v_sync edge-detect register=0.
REQ-020 After rst_n deasserts, the block SHALL produce valid outputs for pixels presented from the first following clk edge onward.
- The first RAM_LAT+1 output cycles after release SHALL be blank.
REQ-021 Reset asserted mid-frame SHALL abort all in-flight pixels with no stale colour emitted after release.

Verification
REQ-022 Bench with RAM_LAT=1, mode_q=00: pixel x=5, y=3, DE=1 -> addr=322, rd_en=1 in cycle n+1; imgData=F800 returned -> r=F, g=0, b=0, de_o=1 in cycle n+2.
REQ-023 Bench with mode_q=01: x=330, y=250 -> addr=3210; x=639, y=479 -> addr=76799.
REQ-024 Bench with mode_q=10, border_rgb=A5C:
- x=100, y=200 -> rd_en=0, colour A5C.
- x=160, y=120 -> addr=0.
- x=479, y=359 -> addr=76799.
REQ-025 Bench with mode_q=11: x=0 -> FFF; x=80 -> FF0; x=639 -> 000; rd_en=0 throughout; with RAM_LAT=3, colours SHALL appear at n+4.
REQ-026 Bench driving mode=10 mid-frame while mode_q=00 -> addresses remain mode-00 until the cycle after the next v_sync rise, then switch to mode 10.
REQ-027 Bench asserting rst_n=0 mid-line while de_o=1 -> all outputs 0 immediately and mode_q=00; after release, the first RAM_LAT+1 output cycles are blank.

Source files
------------

// File: rtl/frame_buf_reader.sv
// Frame-buffer reader: maps each display pixel to a frame-RAM address for the
// selected display mode, then realigns colour, DE and syncs with the RAM data.
module frame_buf_reader #(
    parameter int IMG_W   = 320,
    parameter int IMG_H   = 240,
    parameter int DISP_W  = 640,
    parameter int DISP_H  = 480,
    parameter int RAM_LAT = 1,
    parameter int AW      = $clog2(IMG_W*IMG_H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          DE,
    input  logic [9:0]    x_pixel,
    input  logic [9:0]    y_pixel,
    input  logic          h_sync,
    input  logic          v_sync,
    input  logic [1:0]    mode,
    input  logic [11:0]   border_rgb,
    output logic [AW-1:0] addr,
    output logic          rd_en,
    input  logic [15:0]   imgData,
    output logic [3:0]    r_port,
    output logic [3:0]    g_port,
    output logic [3:0]    b_port,
    output logic          de_o,
    output logic          h_sync_o,
    output logic          v_sync_o
);

    localparam int LAST = RAM_LAT - 1;
    localparam logic [31:0] IW = 32'(IMG_W);
    localparam logic [31:0] IH = 32'(IMG_H);
    localparam logic [31:0] DW = 32'(DISP_W);
    localparam logic [31:0] DH = 32'(DISP_H);
    localparam logic [31:0] OX = 32'((DISP_W - IMG_W) / 2);
    localparam logic [31:0] OY = 32'((DISP_H - IMG_H) / 2);
    localparam logic [31:0] BW = 32'(DISP_W / 8);

    typedef enum logic [1:0] {
        SRC_BLANK  = 2'd0,
        SRC_IMAGE  = 2'd1,
        SRC_BORDER = 2'd2,
        SRC_BAR    = 2'd3
    } src_e;

    // Row scaling by the constant image width as a sum of shifted copies.
    function automatic logic [31:0] mul_w(input logic [31:0] v);
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < 32; i++)
            if (IW[i]) acc = acc + (v << i);
        return acc;
    endfunction

    function automatic logic [11:0] bar_rgb(input logic [2:0] idx);
        logic [11:0] c;
        case (idx)
            3'd0:    c = 12'hFFF;
            3'd1:    c = 12'hFF0;
            3'd2:    c = 12'h0FF;
            3'd3:    c = 12'h0F0;
            3'd4:    c = 12'hF0F;
            3'd5:    c = 12'hF00;
            3'd6:    c = 12'h00F;
            default: c = 12'h000;
        endcase
        return c;
    endfunction

    logic [1:0]    mode_q, mode_d;
    logic          vs_q;
    logic [AW-1:0] addr_q, addr_d;
    logic          rd_en_q, rd_en_d;
    src_e          tag_d;
    logic [2:0]    bar_d;
    logic [11:0]   rgb_q, rgb_d;
    logic          de_o_q, hs_o_q, vs_o_q;

    logic [RAM_LAT-1:0][1:0] tag_pipe_q;
    logic [RAM_LAT-1:0][2:0] bar_pipe_q;
    logic [RAM_LAT-1:0]      de_pipe_q;
    logic [RAM_LAT-1:0]      hs_pipe_q;
    logic [RAM_LAT-1:0]      vs_pipe_q;

    logic [31:0] xw, yw, row, col, thr;
    logic        active, in_win;

    assign xw     = 32'(x_pixel);
    assign yw     = 32'(y_pixel);
    assign active = DE && (xw < DW) && (yw < DH);
    assign in_win = (xw >= OX) && (xw < OX + IW) && (yw >= OY) && (yw < OY + IH);

    // The new mode only lands on a v_sync rise, so a frame never mixes modes.
    assign mode_d = (v_sync && !vs_q) ? mode : mode_q;

    always_comb begin
        row     = '0;
        col     = '0;
        rd_en_d = 1'b0;
        tag_d   = SRC_BLANK;
        bar_d   = '0;
        thr     = BW;
        if (active) begin
            unique case (mode_q)
                2'b00: begin
                    row     = yw >> 1;
                    col     = xw >> 1;
                    rd_en_d = 1'b1;
                    tag_d   = SRC_IMAGE;
                end
                2'b01: begin
                    row     = yw % IH;
                    col     = xw % IW;
                    rd_en_d = 1'b1;
                    tag_d   = SRC_IMAGE;
                end
                2'b10: begin
                    if (in_win) begin
                        row     = yw - OY;
                        col     = xw - OX;
                        rd_en_d = 1'b1;
                        tag_d   = SRC_IMAGE;
                    end else begin
                        tag_d   = SRC_BORDER;
                    end
                end
                2'b11: begin
                    tag_d = SRC_BAR;
                    for (int i = 1; i < 8; i++) begin
                        if (xw >= thr) bar_d = 3'(i);
                        thr = thr + BW;
                    end
                end
            endcase
        end
        addr_d = rd_en_d ? AW'(mul_w(row) + col) : '0;
    end

    always_comb begin
        rgb_d = 12'h000;
        case (src_e'(tag_pipe_q[LAST]))
            SRC_IMAGE:  rgb_d = {imgData[15:12], imgData[10:7], imgData[4:1]};
            SRC_BORDER: rgb_d = border_rgb;
            SRC_BAR:    rgb_d = bar_rgb(bar_pipe_q[LAST]);
            default:    rgb_d = 12'h000;
        endcase
        if (!de_pipe_q[LAST]) rgb_d = 12'h000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= 2'b00;
            vs_q       <= 1'b0;
            addr_q     <= '0;
            rd_en_q    <= 1'b0;
            tag_pipe_q <= '0;
            bar_pipe_q <= '0;
            de_pipe_q  <= '0;
            hs_pipe_q  <= '0;
            vs_pipe_q  <= '0;
            rgb_q      <= '0;
            de_o_q     <= 1'b0;
            hs_o_q     <= 1'b0;
            vs_o_q     <= 1'b0;
        end else begin
            mode_q        <= mode_d;
            vs_q          <= v_sync;
            addr_q        <= addr_d;
            rd_en_q       <= rd_en_d;
            tag_pipe_q[0] <= tag_d;
            bar_pipe_q[0] <= bar_d;
            de_pipe_q[0]  <= DE;
            hs_pipe_q[0]  <= h_sync;
            vs_pipe_q[0]  <= v_sync;
            for (int i = 1; i < RAM_LAT; i++) begin
                tag_pipe_q[i] <= tag_pipe_q[i-1];
                bar_pipe_q[i] <= bar_pipe_q[i-1];
                de_pipe_q[i]  <= de_pipe_q[i-1];
                hs_pipe_q[i]  <= hs_pipe_q[i-1];
                vs_pipe_q[i]  <= vs_pipe_q[i-1];
            end
            rgb_q  <= rgb_d;
            de_o_q <= de_pipe_q[LAST];
            hs_o_q <= hs_pipe_q[LAST];
            vs_o_q <= vs_pipe_q[LAST];
        end
    end

    // RGB565 LSBs are dropped when narrowing to 4 bits per channel.
    logic unused_img_bits;
    assign unused_img_bits = ^{imgData[11], imgData[5], imgData[0]};

    assign addr     = addr_q;
    assign rd_en    = rd_en_q;
    assign r_port   = rgb_q[11:8];
    assign g_port   = rgb_q[7:4];
    assign b_port   = rgb_q[3:0];
    assign de_o     = de_o_q;
    assign h_sync_o = hs_o_q;
    assign v_sync_o = vs_o_q;

endmodule

// File: tb/tb_frame_buf_reader.sv
// Bench for frame_buf_reader: two instances (RAM_LAT 1 and 3) share one stimulus
// stream and are compared against a pixel-level reference model.
module tb_frame_buf_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        DE = 1'b0;
    logic [9:0]  x_pixel = '0;
    logic [9:0]  y_pixel = '0;
    logic        h_sync = 1'b0;
    logic        v_sync = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [11:0] border_rgb = 12'hA5C;

    logic [16:0] addr1, addr3;
    logic        rd1, rd3;
    logic [15:0] img1, img3, img3_p;
    logic [3:0]  r1, g1, b1, r3, g3, b3;
    logic        deo1, hso1, vso1, deo3, hso3, vso3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    frame_buf_reader #(.RAM_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .DE(DE), .x_pixel(x_pixel), .y_pixel(y_pixel),
        .h_sync(h_sync), .v_sync(v_sync), .mode(mode), .border_rgb(border_rgb),
        .addr(addr1), .rd_en(rd1), .imgData(img1),
        .r_port(r1), .g_port(g1), .b_port(b1),
        .de_o(deo1), .h_sync_o(hso1), .v_sync_o(vso1));

    frame_buf_reader #(.RAM_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .DE(DE), .x_pixel(x_pixel), .y_pixel(y_pixel),
        .h_sync(h_sync), .v_sync(v_sync), .mode(mode), .border_rgb(border_rgb),
        .addr(addr3), .rd_en(rd3), .imgData(img3),
        .r_port(r3), .g_port(g3), .b_port(b3),
        .de_o(deo3), .h_sync_o(hso3), .v_sync_o(vso3));

    // Frame-RAM contents as a fixed function of address.
    function automatic logic [15:0] ram_word(input logic [16:0] a);
        if (a == 17'd322) return 16'hF800;
        return 16'((32'(a) * 40503) ^ (32'(a) >> 2));
    endfunction

    // Data is due RAM_LAT cycles after the pixel cycle: combinational off the
    // registered address for latency 1, two extra register stages for latency 3.
    always_comb img1 = ram_word(addr1);
    always_ff @(posedge clk) begin
        img3_p <= ram_word(addr3);
        img3   <= img3_p;
    end

    typedef struct {
        int unsigned addr;
        bit          rd;
        logic [11:0] rgb;
    } pix_t;

    function automatic logic [11:0] bar_col(input int i);
        case (i)
            0: return 12'hFFF;
            1: return 12'hFF0;
            2: return 12'h0FF;
            3: return 12'h0F0;
            4: return 12'hF0F;
            5: return 12'hF00;
            6: return 12'h00F;
            default: return 12'h000;
        endcase
    endfunction

    function automatic pix_t model(input int x, input int y, input bit de,
                                   input logic [1:0] m, input logic [11:0] brd);
        pix_t p;
        logic [15:0] w;
        p.addr = 0; p.rd = 0; p.rgb = 12'h000;
        if (!de || x >= 640 || y >= 480) return p;
        case (m)
            2'd0: begin p.addr = (y / 2) * 320 + x / 2; p.rd = 1; end
            2'd1: begin p.addr = (y % 240) * 320 + x % 320; p.rd = 1; end
            2'd2: if (x >= 160 && x < 480 && y >= 120 && y < 360) begin
                      p.addr = (y - 120) * 320 + (x - 160); p.rd = 1;
                  end else p.rgb = brd;
            default: p.rgb = bar_col(x / 80);
        endcase
        if (p.rd) begin
            w = ram_word(17'(p.addr));
            p.rgb = {w[15:12], w[10:7], w[4:1]};
        end
        return p;
    endfunction

    logic [1:0]  mode_m = 2'b00;
    bit          vs_prev_m = 1'b0;
    logic [14:0] hist[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_hist();
        hist.delete();
        repeat (6) hist.push_front(15'h0);
    endtask

    // Present one pixel, clock it in, then check both instances.
    task automatic step(input int x, input int y, input bit de, input bit hs,
                        input bit vs, input logic [1:0] m);
        pix_t p;
        DE = de; x_pixel = 10'(x); y_pixel = 10'(y);
        h_sync = hs; v_sync = vs; mode = m;
        p = model(x, y, de, mode_m, border_rgb);
        @(posedge clk);
        if (vs && !vs_prev_m) mode_m = m;
        vs_prev_m = vs;
        hist.push_front({de, hs, vs, p.rgb});
        if (hist.size() > 8) void'(hist.pop_back());
        #1;
        chk("addr1", 32'(addr1), p.addr);
        chk("rd1",   32'(rd1),   32'(p.rd));
        chk("addr3", 32'(addr3), p.addr);
        chk("rd3",   32'(rd3),   32'(p.rd));
        chk("out1", 32'({deo1, hso1, vso1, r1, g1, b1}), 32'(hist[1]));
        chk("out3", 32'({deo3, hso3, vso3, r3, g3, b3}), 32'(hist[3]));
    endtask

    task automatic set_mode(input logic [1:0] m);
        step(0, 0, 0, 0, 0, m);
        step(0, 0, 0, 0, 1, m);
        step(0, 0, 0, 0, 0, m);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out1", 32'({deo1, hso1, vso1, r1, g1, b1, rd1, addr1}), 32'h0);
        chk("rst_out3", 32'({deo3, hso3, vso3, r3, g3, b3, rd3, addr3}), 32'h0);
        mode_m = 2'b00;
        vs_prev_m = 1'b0;
        clear_hist();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold", 32'({deo1, r1, g1, b1, rd1, deo3, r3, g3, b3, rd3}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_hist();
        #3;
        chk("por_out", 32'({deo1, r1, g1, b1, rd1, addr1, deo3, r3, g3, b3, rd3}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // mode 00, 2x upscale
        step(5, 3, 1, 0, 0, 2'd0);
        chk("r022_addr", 32'({rd1, addr1}), 32'({1'b1, 17'd322}));
        step(6, 3, 1, 0, 0, 2'd0);
        chk("r022_rgb", 32'({deo1, r1, g1, b1}), 32'h1F00);

        // mode 01, tile
        set_mode(2'd1);
        step(330, 250, 1, 0, 0, 2'd1);
        chk("r023_tile", 32'(addr1), 32'd3210);
        step(639, 479, 1, 0, 0, 2'd1);
        chk("r023_corner", 32'(addr1), 32'd76799);

        // mode 10, centred window with border
        set_mode(2'd2);
        step(100, 200, 1, 0, 0, 2'd2);
        chk("r024_rd", 32'(rd1), 32'd0);
        step(160, 120, 1, 0, 0, 2'd2);
        chk("r024_org", 32'({rd1, addr1}), 32'({1'b1, 17'd0}));
        chk("r024_border", 32'({r1, g1, b1}), 32'hA5C);
        step(479, 359, 1, 0, 0, 2'd2);
        chk("r024_end", 32'(addr1), 32'd76799);

        // mode 11, colour bars
        set_mode(2'd3);
        step(0, 10, 1, 0, 0, 2'd3);
        step(80, 10, 1, 0, 0, 2'd3);
        chk("r025_bar0", 32'({r1, g1, b1}), 32'hFFF);
        step(639, 10, 1, 0, 0, 2'd3);
        chk("r025_bar1", 32'({r1, g1, b1}), 32'hFF0);
        chk("r025_rd", 32'({rd1, rd3}), 32'd0);
        step(5, 10, 1, 0, 0, 2'd3);
        chk("r025_bar7", 32'({deo1, r1, g1, b1}), 32'h1000);
        chk("r025_lat3", 32'({r3, g3, b3}), 32'hFFF);

        // mid-frame mode request only takes effect after the v_sync rise
        set_mode(2'd0);
        step(10, 10, 1, 0, 0, 2'd2);
        chk("r026_hold", 32'(addr1), 32'd1605);
        step(10, 10, 1, 0, 1, 2'd2);
        chk("r026_rise", 32'(addr1), 32'd1605);
        step(170, 130, 1, 0, 0, 2'd2);
        chk("r026_switch", 32'(addr1), 32'd3210);

        // reset mid-line while de_o is high
        step(200, 200, 1, 0, 0, 2'd2);
        step(201, 200, 1, 0, 0, 2'd2);
        chk("r027_de", 32'({deo1, deo3}), 32'b11);
        do_reset();
        step(10, 10, 1, 0, 0, 2'd2);
        chk("r027_mode", 32'(addr1), 32'd1605);
        step(11, 10, 1, 0, 0, 2'd2);
        step(12, 10, 1, 0, 0, 2'd2);

        // randomized traffic, including out-of-range coordinates and resets
        for (int k = 0; k < 3000; k++) begin
            if (k % 1000 == 999) do_reset();
            step(int'($urandom_range(0, 700)), int'($urandom_range(0, 520)),
                 ($urandom % 8) != 0, ($urandom % 16) == 0,
                 ($urandom % 24) == 0, 2'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
